// File: rtl/hw_accel_dma_streamer.sv
// Purpose: packs 8-bit grayscale pixels into DMA stream words {00,p,p,p}, framed with tlast per transfer and per frame.
// Latency: one cycle from pixel accept to dma_tvalid when the output register is empty or draining.
// Backpressure: 2-entry skid (output + skid register); pix_ready is a flop that drops once the skid register fills.
module hw_accel_dma_streamer #(
    parameter int DATA_WIDTH          = 32,
    parameter int FRAME_WIDTH         = 640,
    parameter int FRAME_HEIGHT        = 480,
    parameter int DMA_TRANSFER_LENGTH = 1920
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [7:0]              pix_data,
    input  logic                    pix_sof,
    output logic                    dma_tvalid,
    input  logic                    dma_tready,
    output logic [DATA_WIDTH-1:0]   dma_tdata,
    output logic [DATA_WIDTH/8-1:0] dma_tkeep,
    output logic                    dma_tlast,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    sof_err
);
    localparam int TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int PCW   = $clog2(TOTAL + 1);
    localparam int WCW   = (DMA_TRANSFER_LENGTH > 1) ? $clog2(DMA_TRANSFER_LENGTH) : 1;
    localparam int KW    = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ARMED, STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [7:0] pix;
        logic       last;
        logic       eof;
    } ent_t;

    state_t         state, state_nxt;
    ent_t           out_q, out_n, skid_q, skid_n, new_ent;
    logic           out_vld, out_vld_n, skid_vld, skid_vld_n;
    logic           pix_ready_n;
    logic [PCW-1:0] pix_cnt;
    logic [WCW-1:0] word_cnt;
    logic           push, pop, last_pix;

    // Pixels without sof in ARMED are accepted but never pushed.
    assign push     = pix_valid && pix_ready &&
                      ((state == STREAM) || ((state == ARMED) && pix_sof));
    assign pop      = out_vld && dma_tready;
    assign last_pix = (pix_cnt == PCW'(TOTAL - 1));

    always_comb begin
        new_ent      = '0;
        new_ent.pix  = pix_data;
        new_ent.eof  = last_pix;
        new_ent.last = last_pix || (word_cnt == WCW'(DMA_TRANSFER_LENGTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARMED;
            ARMED:   if (push) state_nxt = last_pix ? DRAIN : STREAM;
            STREAM:  if (push && last_pix) state_nxt = DRAIN;
            DRAIN:   if (pop && out_q.eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        out_vld_n  = out_vld;
        out_n      = out_q;
        skid_vld_n = skid_vld;
        skid_n     = skid_q;
        if (!out_vld || pop) begin
            if (skid_vld) begin
                out_vld_n  = 1'b1;
                out_n      = skid_q;
                skid_vld_n = push;
                if (push) skid_n = new_ent;
            end else begin
                out_vld_n = push;
                if (push) out_n = new_ent;
            end
        end else if (push) begin
            skid_vld_n = 1'b1;
            skid_n     = new_ent;
        end
        if (abort) begin
            out_vld_n  = 1'b0;
            skid_vld_n = 1'b0;
            out_n      = '0;
            skid_n     = '0;
        end
        pix_ready_n = ((state_nxt == ARMED) || (state_nxt == STREAM)) && !skid_vld_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_q      <= '0;
            skid_q     <= '0;
            out_vld    <= 1'b0;
            skid_vld   <= 1'b0;
            pix_ready  <= 1'b0;
            pix_cnt    <= '0;
            word_cnt   <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_q      <= out_n;
            skid_q     <= skid_n;
            out_vld    <= out_vld_n;
            skid_vld   <= skid_vld_n;
            pix_ready  <= pix_ready_n;
            frame_done <= (state == DRAIN) && pop && out_q.eof && !abort;
            if ((state == STREAM) && push && pix_sof) sof_err <= 1'b1;
            if (abort || ((state == IDLE) && start)) begin
                pix_cnt  <= '0;
                word_cnt <= '0;
            end else if (push) begin
                pix_cnt  <= pix_cnt + 1'b1;
                word_cnt <= new_ent.last ? '0 : word_cnt + 1'b1;
            end
        end
    end

    assign dma_tvalid = out_vld;
    assign dma_tdata  = DATA_WIDTH'({8'h00, out_q.pix, out_q.pix, out_q.pix});
    assign dma_tkeep  = {KW{out_vld}};
    assign dma_tlast  = out_vld && out_q.last;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_hw_accel_dma_streamer.sv
// Purpose: scoreboard bench for hw_accel_dma_streamer with a 4x2 frame and 3-word transfers.
// Latency: expected words are queued on pixel accept; a monitor pops and compares on each DMA handshake.
// Backpressure: dma_tready stalls and abort/reset flushes are driven from directed sequences.
module tb_hw_accel_dma_streamer;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, pix_valid, pix_sof, dma_tready;
    logic [7:0]  pix_data;
    logic        pix_ready, dma_tvalid, dma_tlast, busy, frame_done, sof_err;
    logic [31:0] dma_tdata;
    logic [3:0]  dma_tkeep;

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
        logic        eof;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] tlast_tab = 8'b1010_0100;  // tlast on words 2, 5, 7

    hw_accel_dma_streamer #(
        .DATA_WIDTH(32), .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .DMA_TRANSFER_LENGTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
        .dma_tvalid(dma_tvalid), .dma_tready(dma_tready), .dma_tdata(dma_tdata),
        .dma_tkeep(dma_tkeep), .dma_tlast(dma_tlast),
        .busy(busy), .frame_done(frame_done), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] p, input int k);
        exp_t e;
        e.dat  = {8'h00, p, p, p};
        e.last = tlast_tab[k];
        e.eof  = (k == 7);
        return e;
    endfunction

    // Offers one pixel from a negedge until accepted; queues its word when push is set.
    task automatic send_pix(input logic [7:0] p, input logic sof, input logic push, input int k);
        logic acc;
        int   n;
        n         = 0;
        acc       = 1'b0;
        pix_valid = 1'b1;
        pix_data  = p;
        pix_sof   = sof;
        while (!acc) begin
            acc = pix_ready;
            if (acc && push) exp_q.push_back(mk(p, k));
            @(negedge clk);
            n++;
            if (!acc && n > 100) begin
                checks++;
                errors++;
                $display("FAIL pix_accept_timeout pixel=%h actual=not_accepted required=accepted", p);
                break;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int sof2);
        do_start();
        for (int k = 0; k < 8; k++)
            send_pix(base + 8'(k), (k == 0) || (k == sof2), 1'b1, k);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("words_outstanding", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tvalid", dma_tvalid, 0);
        chk("rst_tlast", dma_tlast, 0);
        chk("rst_tdata", dma_tdata, 0);
        chk("rst_tkeep", dma_tkeep, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sof_err", sof_err, 0);
    endtask

    // Monitor: compares each handshake against the scoreboard, holds under stall, and frame_done timing.
    initial begin
        logic        prev_stall, fd_exp;
        logic [31:0] prev_dat;
        exp_t        e;
        prev_stall = 1'b0;
        fd_exp     = 1'b0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (fd_exp || frame_done) chk("frame_done", frame_done, fd_exp);
            fd_exp = 1'b0;
            if (prev_stall && rst_n) begin
                chk("hold_tvalid", dma_tvalid, 1);
                chk("hold_tdata", dma_tdata, prev_dat);
            end
            if (dma_tvalid && dma_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", dma_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", dma_tdata, e.dat);
                    chk("tlast", dma_tlast, e.last);
                    chk("tkeep", dma_tkeep, 4'hF);
                    fd_exp = e.eof && !abort && rst_n;
                end
            end
            prev_stall = dma_tvalid && !dma_tready && !abort && rst_n;
            prev_dat   = dma_tdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; dma_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_pix_ready", pix_ready, 0);

        // Basic frame: 0x10..0x17
        do_start();
        chk("armed_busy", busy, 1);
        chk("armed_pix_ready", pix_ready, 1);
        for (int k = 0; k < 8; k++) send_pix(8'h10 + 8'(k), k == 0, 1'b1, k);
        wait_drain();
        chk("done_busy", busy, 0);
        chk("clean_sof_err", sof_err, 0);

        // Pixels before sof are discarded in ARMED
        do_start();
        for (int k = 0; k < 3; k++) send_pix(8'h21 + 8'(k), 1'b0, 1'b0, 0);
        send_pix(8'h55, 1'b1, 1'b1, 0);
        for (int k = 1; k < 8; k++) send_pix(8'h55 + 8'(k), 1'b0, 1'b1, k);
        wait_drain();

        // Five-cycle DMA stall mid-frame
        fork
            send_frame(8'h30, 0);
            begin
                repeat (4) @(negedge clk);
                dma_tready = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                chk("stall_pix_ready", pix_ready, 0);
                chk("stall_tvalid", dma_tvalid, 1);
                repeat (3) @(negedge clk);
                dma_tready = 1'b1;
            end
        join
        wait_drain();

        // Stray sof on pixel 4
        chk("pre_sof_err", sof_err, 0);
        send_frame(8'hA0, 4);
        wait_drain();
        chk("sof_err_set", sof_err, 1);

        // Abort with two words buffered
        do_start();
        for (int k = 0; k < 5; k++) send_pix(8'h40 + 8'(k), k == 0, 1'b1, k);
        wait_drain();
        dma_tready = 1'b0;
        send_pix(8'h45, 1'b0, 1'b0, 5);
        send_pix(8'h46, 1'b0, 1'b0, 6);
        chk("pre_abort_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_tvalid", dma_tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pix_ready", pix_ready, 0);
        @(negedge clk);
        dma_tready = 1'b1;
        repeat (5) @(negedge clk);
        chk("sof_err_sticky", sof_err, 1);
        send_frame(8'h60, 0);
        wait_drain();

        // Reset mid-frame with buffered words
        do_start();
        dma_tready = 1'b0;
        send_pix(8'h70, 1'b1, 1'b0, 0);
        send_pix(8'h71, 1'b0, 1'b0, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        dma_tready = 1'b1;
        @(negedge clk);
        send_frame(8'h80, 0);
        wait_drain();
        chk("final_sof_err", sof_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
